// File: rtl/bpred_update_ctrl.sv
// bpred_update_ctrl
// -----------------
// Write-port scheduler for the branch predictor counter and BTB tables.
// After reset it sweeps both tables to a known state (counters weakly
// not-taken, BTB targets zero). It buffers execute-stage resolution updates
// in a small FIFO. It then arbitrates the single shared write port between
// buffered updates and external BTB preload requests. All write strobes are
// registered so they can drive the table RAMs directly.
//
// Parameters
//   IDX_W       table index width (2^IDX_W entries per table)
//   FIFO_DEPTH  update FIFO depth, power of two in 2..16
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   execute_bpredictor_*         resolved-branch update from execute
//   upd_ready                    FIFO not full (combinational)
//   preload_wren/idx/target      BTB preload request, held until acked
//   preload_ack                  one-cycle grant pulse for a preload
//   cnt_we/cnt_widx/cnt_wdata    counter table write port
//   btb_we/btb_widx/btb_wdata    BTB write port (target[31:2])
//   init_busy                    clear sweep in progress
//   soin_bpredictor_debug_sel    statistics select
//   upd_debug                    selected statistic
//
// Build option
//   BPRED_UPD_STATS_EN  when defined, adds saturating counters for accepted,
//                       mispredicted and dropped updates, readable on
//                       upd_debug. When undefined, upd_debug is tied to 0.

module bpred_update_ctrl #(
  parameter int IDX_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              execute_bpredictor_update,
  input  logic [31:0]       execute_bpredictor_PC4,
  input  logic [31:0]       execute_bpredictor_target,
  input  logic              execute_bpredictor_dir,
  input  logic              execute_bpredictor_miss,
  input  logic [1:0]        execute_bpredictor_cnt,
  output logic              upd_ready,
  input  logic              preload_wren,
  input  logic [IDX_W-1:0]  preload_idx,
  input  logic [29:0]       preload_target,
  output logic              preload_ack,
  output logic              cnt_we,
  output logic [IDX_W-1:0]  cnt_widx,
  output logic [1:0]        cnt_wdata,
  output logic              btb_we,
  output logic [IDX_W-1:0]  btb_widx,
  output logic [29:0]       btb_wdata,
  output logic              init_busy,
  input  logic [1:0]        soin_bpredictor_debug_sel,
  output logic [31:0]       upd_debug
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [29:0]      target;
    logic             dir;
    logic             miss;
    logic [1:0]       cnt;
  } upd_entry_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] sweep, sweep_nxt;
  logic last_grant_pre, last_grant_pre_nxt;

  logic             cnt_we_nxt, btb_we_nxt, preload_ack_nxt, init_busy_nxt;
  logic [IDX_W-1:0] cnt_widx_nxt, btb_widx_nxt;
  logic [1:0]       cnt_wdata_nxt;
  logic [29:0]      btb_wdata_nxt;

  upd_entry_t       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   fifo_count;
  upd_entry_t       new_entry, head;
  logic             push, pop, fifo_empty;
  logic             grant_pre, grant_fifo;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'b01;
    end else begin
      if (c != 2'b00) r = c - 2'b01;
    end
    return r;
  endfunction

  // The table index is taken from PC+4 minus one word, so that it names
  // the branch itself. PC4 = 0 wraps to the top entry.
  always_comb begin
    new_entry        = '0;
    new_entry.idx    = execute_bpredictor_PC4[IDX_W+1:2] - IDX_W'(1);
    new_entry.target = execute_bpredictor_target[31:2];
    new_entry.dir    = execute_bpredictor_dir;
    new_entry.miss   = execute_bpredictor_miss;
    new_entry.cnt    = execute_bpredictor_cnt;
  end

  assign upd_ready  = (fifo_count != FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign push       = execute_bpredictor_update && upd_ready;
  assign head       = fifo_mem[rd_ptr];

  // Round-robin between the two sources. A preload loses only when the
  // previous grant was also a preload and an update is waiting.
  always_comb begin
    grant_pre  = (state == ST_RUN) && preload_wren &&
                 !(!fifo_empty && last_grant_pre);
    grant_fifo = (state == ST_RUN) && !fifo_empty && !grant_pre;
  end

  assign pop = grant_fifo;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    state_nxt          = state;
    sweep_nxt          = sweep;
    last_grant_pre_nxt = last_grant_pre;
    cnt_we_nxt         = 1'b0;
    cnt_widx_nxt       = '0;
    cnt_wdata_nxt      = 2'b00;
    btb_we_nxt         = 1'b0;
    btb_widx_nxt       = '0;
    btb_wdata_nxt      = '0;
    preload_ack_nxt    = 1'b0;
    // init_busy lags the state by one edge, so it drops in the cycle
    // after the final clear write.
    init_busy_nxt      = (state == ST_CLEAR);
    case (state)
      ST_CLEAR: begin
        cnt_we_nxt    = 1'b1;
        cnt_widx_nxt  = sweep;
        cnt_wdata_nxt = 2'b01;
        btb_we_nxt    = 1'b1;
        btb_widx_nxt  = sweep;
        sweep_nxt     = sweep + IDX_W'(1);
        if (sweep == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (grant_pre) begin
          btb_we_nxt         = 1'b1;
          btb_widx_nxt       = preload_idx;
          btb_wdata_nxt      = preload_target;
          preload_ack_nxt    = 1'b1;
          last_grant_pre_nxt = 1'b1;
        end else if (grant_fifo) begin
          cnt_we_nxt         = 1'b1;
          cnt_widx_nxt       = head.idx;
          cnt_wdata_nxt      = sat_update(head.cnt, head.dir);
          btb_we_nxt         = head.dir;
          btb_widx_nxt       = head.idx;
          btb_wdata_nxt      = head.target;
          last_grant_pre_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_CLEAR;
      sweep          <= '0;
      last_grant_pre <= 1'b0;
      cnt_we         <= 1'b0;
      cnt_widx       <= '0;
      cnt_wdata      <= 2'b00;
      btb_we         <= 1'b0;
      btb_widx       <= '0;
      btb_wdata      <= '0;
      preload_ack    <= 1'b0;
      init_busy      <= 1'b1;
    end else begin
      state          <= state_nxt;
      sweep          <= sweep_nxt;
      last_grant_pre <= last_grant_pre_nxt;
      cnt_we         <= cnt_we_nxt;
      cnt_widx       <= cnt_widx_nxt;
      cnt_wdata      <= cnt_wdata_nxt;
      btb_we         <= btb_we_nxt;
      btb_widx       <= btb_widx_nxt;
      btb_wdata      <= btb_wdata_nxt;
      preload_ack    <= preload_ack_nxt;
      init_busy      <= init_busy_nxt;
    end
  end

`ifdef BPRED_UPD_STATS_EN
  logic [15:0] stat_accepted, stat_missed, stat_dropped;
  logic        drop;
  logic        unused_bits;

  assign drop = execute_bpredictor_update && !upd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_accepted <= '0;
      stat_missed   <= '0;
      stat_dropped  <= '0;
    end else begin
      if (push && stat_accepted != 16'hFFFF)
        stat_accepted <= stat_accepted + 16'd1;
      if (push && execute_bpredictor_miss && stat_missed != 16'hFFFF)
        stat_missed <= stat_missed + 16'd1;
      if (drop && stat_dropped != 16'hFFFF)
        stat_dropped <= stat_dropped + 16'd1;
    end
  end

  always_comb begin
    upd_debug = 32'h0;
    case (soin_bpredictor_debug_sel)
      2'd0:    upd_debug = {16'h0, stat_accepted};
      2'd1:    upd_debug = {16'h0, stat_missed};
      2'd2:    upd_debug = {16'h0, stat_dropped};
      default: upd_debug = 32'({fifo_count, state});
    endcase
  end

  assign unused_bits = ^{execute_bpredictor_PC4[31:IDX_W+2],
                         execute_bpredictor_PC4[1:0],
                         execute_bpredictor_target[1:0], head.miss};
`else
  logic unused_bits;

  assign upd_debug   = 32'h0;
  assign unused_bits = ^{execute_bpredictor_PC4[31:IDX_W+2],
                         execute_bpredictor_PC4[1:0],
                         execute_bpredictor_target[1:0], head.miss,
                         soin_bpredictor_debug_sel};
`endif

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Directed testbench for bpred_update_ctrl, built with IDX_W = 4 and
// FIFO_DEPTH = 4. Expected values are worked out by hand below each step.

module tb_bpred_update_ctrl;

  logic        clk;
  logic        reset;
  logic        execute_bpredictor_update;
  logic [31:0] execute_bpredictor_PC4;
  logic [31:0] execute_bpredictor_target;
  logic        execute_bpredictor_dir;
  logic        execute_bpredictor_miss;
  logic [1:0]  execute_bpredictor_cnt;
  logic        upd_ready;
  logic        preload_wren;
  logic [3:0]  preload_idx;
  logic [29:0] preload_target;
  logic        preload_ack;
  logic        cnt_we;
  logic [3:0]  cnt_widx;
  logic [1:0]  cnt_wdata;
  logic        btb_we;
  logic [3:0]  btb_widx;
  logic [29:0] btb_wdata;
  logic        init_busy;
  logic [1:0]  soin_bpredictor_debug_sel;
  logic [31:0] upd_debug;

  int checks = 0;
  int errors = 0;

  bpred_update_ctrl #(.IDX_W(4), .FIFO_DEPTH(4)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .execute_bpredictor_update (execute_bpredictor_update),
    .execute_bpredictor_PC4    (execute_bpredictor_PC4),
    .execute_bpredictor_target (execute_bpredictor_target),
    .execute_bpredictor_dir    (execute_bpredictor_dir),
    .execute_bpredictor_miss   (execute_bpredictor_miss),
    .execute_bpredictor_cnt    (execute_bpredictor_cnt),
    .upd_ready                 (upd_ready),
    .preload_wren              (preload_wren),
    .preload_idx               (preload_idx),
    .preload_target            (preload_target),
    .preload_ack               (preload_ack),
    .cnt_we                    (cnt_we),
    .cnt_widx                  (cnt_widx),
    .cnt_wdata                 (cnt_wdata),
    .btb_we                    (btb_we),
    .btb_widx                  (btb_widx),
    .btb_wdata                 (btb_wdata),
    .init_busy                 (init_busy),
    .soin_bpredictor_debug_sel (soin_bpredictor_debug_sel),
    .upd_debug                 (upd_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic upd, input logic [31:0] pc4,
                               input logic [31:0] target, input logic dir,
                               input logic miss, input logic [1:0] cnt);
    execute_bpredictor_update = upd;
    execute_bpredictor_PC4    = pc4;
    execute_bpredictor_target = target;
    execute_bpredictor_dir    = dir;
    execute_bpredictor_miss   = miss;
    execute_bpredictor_cnt    = cnt;
  endtask

  task automatic checkFifoWrite(input string tag, input logic [31:0] idx,
                                input logic [31:0] cdata, input logic [31:0] bwe,
                                input logic [31:0] bdata);
    checkOutput({tag, "_cnt_we"},    32'(cnt_we),      1);
    checkOutput({tag, "_cnt_widx"},  32'(cnt_widx),    idx);
    checkOutput({tag, "_cnt_wdata"}, 32'(cnt_wdata),   cdata);
    checkOutput({tag, "_btb_we"},    32'(btb_we),      bwe);
    checkOutput({tag, "_ack"},       32'(preload_ack), 0);
    if (bwe != 0) begin
      checkOutput({tag, "_btb_widx"},  32'(btb_widx),  idx);
      checkOutput({tag, "_btb_wdata"}, 32'(btb_wdata), bdata);
    end
  endtask

  // Assert reset over two edges, then release it just after an edge so the
  // next edge issues clear write 0.
  task automatic resetDut();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pc_tab [4];
    logic [31:0] exp_cnt [4];
    logic [31:0] exp_dir [4];
    logic [31:0] q_idx [3];
    logic [31:0] q_cnt [3];
    logic [31:0] q_tgt [3];

    reset = 1'b1;
    preload_wren = 1'b0;
    preload_idx = 4'd0;
    preload_target = 30'h0;
    soin_bpredictor_debug_sel = 2'd0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);

    // ---------------- reset state ----------------
    tick();
    tick();
    checkOutput("rst_cnt_we",    32'(cnt_we),      0);
    checkOutput("rst_btb_we",    32'(btb_we),      0);
    checkOutput("rst_cnt_widx",  32'(cnt_widx),    0);
    checkOutput("rst_btb_wdata", 32'(btb_wdata),   0);
    checkOutput("rst_ack",       32'(preload_ack), 0);
    checkOutput("rst_init_busy", 32'(init_busy),   1);
    checkOutput("rst_upd_ready", 32'(upd_ready),   1);
    checkOutput("rst_debug",     upd_debug,        0);

    // ---------------- clear sweep with a preload waiting ----------------
    preload_wren   = 1'b1;
    preload_idx    = 4'd5;
    preload_target = 30'h1234567;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput($sformatf("clr%0d_cnt_we", i),    32'(cnt_we),      1);
      checkOutput($sformatf("clr%0d_cnt_widx", i),  32'(cnt_widx),    i);
      checkOutput($sformatf("clr%0d_cnt_wdata", i), 32'(cnt_wdata),   1);
      checkOutput($sformatf("clr%0d_btb_we", i),    32'(btb_we),      1);
      checkOutput($sformatf("clr%0d_btb_widx", i),  32'(btb_widx),    i);
      checkOutput($sformatf("clr%0d_btb_wdata", i), 32'(btb_wdata),   0);
      checkOutput($sformatf("clr%0d_ack", i),       32'(preload_ack), 0);
      checkOutput($sformatf("clr%0d_busy", i),      32'(init_busy),   1);
    end
    // Cycle 17: sweep done, the waiting preload gets the port.
    tick();
    checkOutput("c17_init_busy", 32'(init_busy),   0);
    checkOutput("pre_ack",       32'(preload_ack), 1);
    checkOutput("pre_btb_we",    32'(btb_we),      1);
    checkOutput("pre_btb_widx",  32'(btb_widx),    5);
    checkOutput("pre_btb_wdata", 32'(btb_wdata),   32'h1234567);
    checkOutput("pre_cnt_we",    32'(cnt_we),      0);
    preload_wren = 1'b0;

    // ---------------- single updates in RUN ----------------
    // PC4=128 -> PC4[5:2]=0, minus 1 wraps to 15; cnt 3 taken stays 3;
    // target 0x200 -> 0x80.
    applyStimulus(1'b1, 32'd128, 32'h200, 1'b1, 1'b0, 2'd3);
    tick();
    checkOutput("u1_push_cnt_we", 32'(cnt_we),      0);
    checkOutput("u1_push_ack",    32'(preload_ack), 0);
    checkOutput("u1_push_ready",  32'(upd_ready),   1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    tick();
    checkFifoWrite("u1", 15, 3, 1, 32'h80);

    // PC4=0 -> idx 15; cnt 0 not-taken stays 0; no BTB write.
    applyStimulus(1'b1, 32'd0, 32'h44, 1'b0, 1'b1, 2'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    tick();
    checkFifoWrite("u2", 15, 0, 0, 0);

    // PC4=0x24 -> 9-1 = idx 8; cnt 1 taken -> 2; target 0x1000 -> 0x400.
    applyStimulus(1'b1, 32'h24, 32'h1000, 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    tick();
    checkFifoWrite("u3", 8, 2, 1, 32'h400);

    // PC4=0x104 -> 65 mod 16 = 1, minus 1 = idx 0; cnt 2 not-taken -> 1.
    applyStimulus(1'b1, 32'h104, 32'h0, 1'b0, 1'b0, 2'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    tick();
    checkFifoWrite("u4", 0, 1, 0, 0);
    tick();
    checkOutput("idle_cnt_we", 32'(cnt_we), 0);
    checkOutput("idle_btb_we", 32'(btb_we), 0);

    // ---------------- five updates during clear ----------------
    pc_tab  = '{32'd8, 32'd12, 32'd16, 32'd20};
    exp_cnt = '{2, 0, 3, 2};
    exp_dir = '{1, 0, 1, 0};
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, pc_tab[k], 32'h100 * (k + 1), exp_dir[k][0],
                    (k % 2 == 0), (k == 0) ? 2'd1 : (k == 1) ? 2'd1 : (k == 2) ? 2'd2 : 2'd3);
      tick();
      checkOutput($sformatf("fill%0d_ready", k), 32'(upd_ready), (k < 3) ? 1 : 0);
    end
    // Fifth update (PC4=60 -> idx 14) arrives with the FIFO full.
    applyStimulus(1'b1, 32'd60, 32'h3C0, 1'b1, 1'b1, 2'd1);
    tick();
    checkOutput("drop_ready", 32'(upd_ready), 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    soin_bpredictor_debug_sel = 2'd2;
    #1;
`ifdef BPRED_UPD_STATS_EN
    checkOutput("stat_dropped", upd_debug, 1);
    soin_bpredictor_debug_sel = 2'd0;
    #1;
    checkOutput("stat_accepted", upd_debug, 4);
    soin_bpredictor_debug_sel = 2'd1;
    #1;
    checkOutput("stat_missed", upd_debug, 2);
    soin_bpredictor_debug_sel = 2'd3;
    #1;
    checkOutput("stat_occ_state", upd_debug, 8);
`else
    checkOutput("debug_off", upd_debug, 0);
`endif
    soin_bpredictor_debug_sel = 2'd0;
    for (int i = 0; i < 11; i++) tick();
    checkOutput("fill_clr15_widx", 32'(cnt_widx),  15);
    checkOutput("fill_clr15_busy", 32'(init_busy), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkFifoWrite($sformatf("drain%0d", k), k + 1, exp_cnt[k], exp_dir[k],
                     32'h40 * (k + 1));
    end
    tick();
    checkOutput("drain_done_cnt_we", 32'(cnt_we),    0);
    checkOutput("drain_done_ready",  32'(upd_ready), 1);

    // ---------------- continuous preload vs 3 queued updates ----------------
    q_idx = '{6, 7, 8};
    q_cnt = '{1, 2, 3};
    q_tgt = '{32'h1C0, 32'h200, 32'h240};
    resetDut();
    preload_wren   = 1'b1;
    preload_idx    = 4'd10;
    preload_target = 30'h2AAAAAA;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'd28 + 32'(4 * k), 32'h700 + 32'(32'h100 * k), 1'b1,
                    1'b0, 2'(k));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 13; i++) tick();
    checkOutput("rr_clr_ack", 32'(preload_ack), 0);
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j % 2 == 0) begin
        checkOutput($sformatf("rr%0d_ack", j),      32'(preload_ack), 1);
        checkOutput($sformatf("rr%0d_cnt_we", j),   32'(cnt_we),      0);
        checkOutput($sformatf("rr%0d_btb_widx", j), 32'(btb_widx),    10);
      end else begin
        checkFifoWrite($sformatf("rr%0d", j), q_idx[j / 2], q_cnt[j / 2], 1,
                       q_tgt[j / 2]);
      end
    end
    tick();
    checkOutput("rr_tail_ack",    32'(preload_ack), 1);
    checkOutput("rr_tail_cnt_we", 32'(cnt_we),      0);
    preload_wren = 1'b0;

    // ---------------- reset with two entries queued in RUN ----------------
    resetDut();
    preload_wren = 1'b1;
    preload_idx  = 4'd9;
    applyStimulus(1'b1, 32'd16, 32'h500, 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(1'b1, 32'd20, 32'h600, 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 14; i++) tick();
    tick();
    checkOutput("mid_ack",       32'(preload_ack), 1);
    checkOutput("mid_btb_widx",  32'(btb_widx),    9);
    checkOutput("mid_init_busy", 32'(init_busy),   0);
    soin_bpredictor_debug_sel = 2'd3;
    #1;
`ifdef BPRED_UPD_STATS_EN
    checkOutput("mid_occ_state", upd_debug, 5);
`else
    checkOutput("mid_debug_off", upd_debug, 0);
`endif
    reset = 1'b1;
    #1;
    checkOutput("async_btb_we",    32'(btb_we),      0);
    checkOutput("async_ack",       32'(preload_ack), 0);
    checkOutput("async_cnt_we",    32'(cnt_we),      0);
    checkOutput("async_init_busy", 32'(init_busy),   1);
    checkOutput("async_ready",     32'(upd_ready),   1);
    checkOutput("async_debug",     upd_debug,        0);
    preload_wren = 1'b0;
    soin_bpredictor_debug_sel = 2'd0;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("restart_cnt_we",   32'(cnt_we),   1);
    checkOutput("restart_cnt_widx", 32'(cnt_widx), 0);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("restart_last_widx", 32'(cnt_widx), 15);
    tick();
    checkOutput("restart_empty_cnt_we", 32'(cnt_we),    0);
    checkOutput("restart_empty_btb_we", 32'(btb_we),    0);
    checkOutput("restart_busy_low",     32'(init_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
